// File: rtl/branch_update_engine_pkg.sv
// Shared types, constants and index helpers for the branch update engine.
package branch_update_engine_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned HIST_W   = 4;
    localparam int unsigned CTR_W    = 2;
    localparam int unsigned HIST_OFS = 0;
    localparam int unsigned NUM_CTR  = 1 << HIST_W;
    localparam int unsigned ENTRY_W  = CTR_W * NUM_CTR;

    localparam logic [CTR_W-1:0]   PHT_INIT_CTR   = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0]   CTR_MAX        = '1;
    localparam logic [ENTRY_W-1:0] PHT_INIT_ENTRY = {NUM_CTR{PHT_INIT_CTR}};

    typedef struct packed {
        logic [IDX_W-1:0]   pidx;
        logic [IDX_W-1:0]   hidx;
        logic               taken;
        logic [HIST_W-1:0]  hist;
        logic [ENTRY_W-1:0] entry;
    } BrUpdateEntry;

    typedef enum logic [0:0] {BUE_SWEEP, BUE_RUN} BrUpdState;

    function automatic logic [IDX_W-1:0] BrUpdPhtIndex(input logic [ADDR_W-1:0] addr);
        return addr[IDX_W+1:2];
    endfunction

    function automatic logic [IDX_W-1:0] BrUpdHistIndex(input logic [ADDR_W-1:0] addr);
        return addr[IDX_W+1+HIST_OFS:2+HIST_OFS];
    endfunction

endpackage

// File: rtl/branch_update_engine_if.sv
// Result-lane inputs and table-write / status outputs of the branch update engine.
interface branch_update_engine_if #(
    parameter int unsigned IN_WIDTH = 2,
    parameter int unsigned DEPTH    = 8
);
    import branch_update_engine_pkg::*;

    logic [IN_WIDTH-1:0]              in_valid;
    logic [IN_WIDTH-1:0]              in_cond;
    logic [IN_WIDTH-1:0]              in_taken;
    logic [IN_WIDTH-1:0]              in_mispred;
    logic [IN_WIDTH-1:0][ADDR_W-1:0]  in_addr;
    logic [IN_WIDTH-1:0][ENTRY_W-1:0] in_entry;
    logic [IN_WIDTH-1:0][HIST_W-1:0]  in_hist;
    logic                             in_ready;
    logic                             pht_we;
    logic [IDX_W-1:0]                 pht_wa;
    logic [ENTRY_W-1:0]               pht_wv;
    logic                             hist_we;
    logic [IDX_W-1:0]                 hist_wa;
    logic [HIST_W-1:0]                hist_wv;
    logic [$clog2(DEPTH+1)-1:0]       q_count;
    logic [7:0]                       drop_cnt;

    modport master (
        output in_valid, in_cond, in_taken, in_mispred, in_addr, in_entry, in_hist,
        input  in_ready, pht_we, pht_wa, pht_wv, hist_we, hist_wa, hist_wv, q_count, drop_cnt
    );

    modport slave (
        input  in_valid, in_cond, in_taken, in_mispred, in_addr, in_entry, in_hist,
        output in_ready, pht_we, pht_wa, pht_wv, hist_we, hist_wa, hist_wv, q_count, drop_cnt
    );
endinterface

// File: rtl/branch_update_engine_fifo.sv
// IN_WIDTH-push / 1-pop circular update queue; pushed lanes are packed in lane order.
module branch_update_engine_fifo
    import branch_update_engine_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 2,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [IN_WIDTH-1:0]              i_push,
    input  BrUpdateEntry [IN_WIDTH-1:0]      i_data,
    input  logic                             i_pop,
    output BrUpdateEntry                     o_head,
    output logic                             o_empty,
    output logic [$clog2(DEPTH+1)-1:0]       o_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    BrUpdateEntry     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_wr_ptr [IN_WIDTH];
    logic [CNT_W-1:0] w_push_n;
    logic             w_pop;

    // Each pushing lane lands after all lower-numbered pushing lanes.
    always_comb begin
        w_push_n = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            w_wr_ptr[i] = r_tail + PTR_W'(w_push_n);
            w_push_n    = w_push_n + CNT_W'(i_push[i]);
        end
    end

    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_head];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (i_push[i]) r_mem[w_wr_ptr[i]] <= i_data[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) r_head <= r_head + PTR_W'(1);
            r_tail  <= r_tail + PTR_W'(w_push_n);
            r_count <= r_count + w_push_n - CNT_W'(w_pop);
        end
    end
endmodule

// File: rtl/branch_update_engine.sv
// Write side of the SAp predictor: queues resolved branches, applies saturating PHT updates,
// drives history recovery on mispredict and sweeps both tables after reset.
module branch_update_engine
    import branch_update_engine_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 2,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    branch_update_engine_if.slave io_bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    BrUpdState          r_state, w_state_d;
    logic [IDX_W-1:0]   r_sweep_idx, w_sweep_idx_d;
    logic               r_in_ready, w_in_ready_d;
    logic               r_pht_we, w_pht_we_d;
    logic [IDX_W-1:0]   r_pht_wa, w_pht_wa_d;
    logic [ENTRY_W-1:0] r_pht_wv, w_pht_wv_d;
    logic               r_hist_we, w_hist_we_d;
    logic [IDX_W-1:0]   r_hist_wa, w_hist_wa_d;
    logic [HIST_W-1:0]  r_hist_wv, w_hist_wv_d;
    logic               r_fwd_valid, w_fwd_valid_d;
    logic [IDX_W-1:0]   r_fwd_idx, w_fwd_idx_d;
    logic [ENTRY_W-1:0] r_fwd_entry, w_fwd_entry_d;
    logic [7:0]         r_drop_cnt, w_drop_cnt_d;

    logic [IN_WIDTH-1:0]         w_qual;
    logic [IN_WIDTH-1:0]         w_push;
    BrUpdateEntry [IN_WIDTH-1:0] w_lane;
    BrUpdateEntry                w_head;
    logic                        w_empty;
    logic                        w_pop;
    logic [CNT_W-1:0]            w_count;
    int                          w_push_n;
    int                          w_qual_n;
    int                          w_count_d;
    logic                        w_rec_valid;
    logic [IDX_W-1:0]            w_rec_idx;
    logic [HIST_W-1:0]           w_rec_hist;
    logic [ENTRY_W-1:0]          w_base;
    logic [ENTRY_W-1:0]          w_new_entry;
    logic [CTR_W-1:0]            w_ctr;
    logic [CTR_W-1:0]            w_ctr_new;
    logic [IDX_W-1:0]            w_unused_hidx;

    always_comb begin
        w_qual   = io_bus.in_valid & io_bus.in_cond;
        w_push   = r_in_ready ? w_qual : '0;
        w_qual_n = 0;
        w_push_n = 0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            w_lane[i].pidx  = BrUpdPhtIndex(io_bus.in_addr[i]);
            w_lane[i].hidx  = BrUpdHistIndex(io_bus.in_addr[i]);
            w_lane[i].taken = io_bus.in_taken[i];
            w_lane[i].hist  = io_bus.in_hist[i];
            w_lane[i].entry = io_bus.in_entry[i];
            w_qual_n        = w_qual_n + int'(w_qual[i]);
            w_push_n        = w_push_n + int'(w_push[i]);
        end
    end

    // Scan from the youngest lane down so the oldest mispredict wins.
    always_comb begin
        w_rec_valid = 1'b0;
        w_rec_idx   = '0;
        w_rec_hist  = '0;
        for (int i = IN_WIDTH - 1; i >= 0; i--) begin
            if (w_qual[i] && io_bus.in_mispred[i]) begin
                w_rec_valid = 1'b1;
                w_rec_idx   = w_lane[i].hidx;
                w_rec_hist  = {io_bus.in_hist[i][HIST_W-1:1], io_bus.in_taken[i]};
            end
        end
    end

    branch_update_engine_fifo #(
        .IN_WIDTH(IN_WIDTH),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (w_push),
        .i_data (w_lane),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_empty(w_empty),
        .o_count(w_count)
    );

    assign w_unused_hidx = w_head.hidx;
    assign w_pop         = (r_state == BUE_RUN) && !w_empty;
    assign w_count_d     = int'(w_count) + w_push_n - int'(w_pop);
    assign w_in_ready_d  = (r_state == BUE_RUN) && (int'(DEPTH) - w_count_d >= int'(IN_WIDTH));

    // Back-to-back updates to the same entry must see the previous result, not the snapshot.
    always_comb begin
        w_base      = (r_fwd_valid && (r_fwd_idx == w_head.pidx)) ? r_fwd_entry : w_head.entry;
        w_ctr       = w_base[w_head.hist*CTR_W +: CTR_W];
        if (w_head.taken) w_ctr_new = (w_ctr == CTR_MAX) ? CTR_MAX : w_ctr + CTR_W'(1);
        else              w_ctr_new = (w_ctr == '0) ? w_ctr : w_ctr - CTR_W'(1);
        w_new_entry = w_base;
        w_new_entry[w_head.hist*CTR_W +: CTR_W] = w_ctr_new;
    end

    always_comb begin
        if (r_in_ready)                            w_drop_cnt_d = r_drop_cnt;
        else if (int'(r_drop_cnt) + w_qual_n > 255) w_drop_cnt_d = 8'hFF;
        else                                       w_drop_cnt_d = r_drop_cnt + 8'(w_qual_n);
    end

    always_comb begin
        w_state_d     = r_state;
        w_sweep_idx_d = r_sweep_idx;
        w_pht_we_d    = 1'b0;
        w_pht_wa_d    = r_pht_wa;
        w_pht_wv_d    = r_pht_wv;
        w_hist_we_d   = 1'b0;
        w_hist_wa_d   = r_hist_wa;
        w_hist_wv_d   = r_hist_wv;
        w_fwd_valid_d = r_fwd_valid;
        w_fwd_idx_d   = r_fwd_idx;
        w_fwd_entry_d = r_fwd_entry;
        case (r_state)
            BUE_SWEEP: begin
                w_pht_we_d    = 1'b1;
                w_pht_wa_d    = r_sweep_idx;
                w_pht_wv_d    = PHT_INIT_ENTRY;
                w_hist_we_d   = 1'b1;
                w_hist_wa_d   = r_sweep_idx;
                w_hist_wv_d   = '0;
                w_fwd_valid_d = 1'b0;
                w_sweep_idx_d = r_sweep_idx + IDX_W'(1);
                if (r_sweep_idx == '1) w_state_d = BUE_RUN;
            end
            BUE_RUN: begin
                if (w_pop) begin
                    w_pht_we_d    = 1'b1;
                    w_pht_wa_d    = w_head.pidx;
                    w_pht_wv_d    = w_new_entry;
                    w_fwd_valid_d = 1'b1;
                    w_fwd_idx_d   = w_head.pidx;
                    w_fwd_entry_d = w_new_entry;
                end else begin
                    w_fwd_valid_d = 1'b0;
                end
                if (w_rec_valid) begin
                    w_hist_we_d = 1'b1;
                    w_hist_wa_d = w_rec_idx;
                    w_hist_wv_d = w_rec_hist;
                end
            end
            default: w_state_d = BUE_SWEEP;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= BUE_SWEEP;
            r_sweep_idx <= '0;
            r_in_ready  <= 1'b0;
            r_pht_we    <= 1'b0;
            r_pht_wa    <= '0;
            r_pht_wv    <= '0;
            r_hist_we   <= 1'b0;
            r_hist_wa   <= '0;
            r_hist_wv   <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_idx   <= '0;
            r_fwd_entry <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_sweep_idx <= w_sweep_idx_d;
            r_in_ready  <= w_in_ready_d;
            r_pht_we    <= w_pht_we_d;
            r_pht_wa    <= w_pht_wa_d;
            r_pht_wv    <= w_pht_wv_d;
            r_hist_we   <= w_hist_we_d;
            r_hist_wa   <= w_hist_wa_d;
            r_hist_wv   <= w_hist_wv_d;
            r_fwd_valid <= w_fwd_valid_d;
            r_fwd_idx   <= w_fwd_idx_d;
            r_fwd_entry <= w_fwd_entry_d;
            r_drop_cnt  <= w_drop_cnt_d;
        end
    end

    assign io_bus.in_ready = r_in_ready;
    assign io_bus.pht_we   = r_pht_we;
    assign io_bus.pht_wa   = r_pht_wa;
    assign io_bus.pht_wv   = r_pht_wv;
    assign io_bus.hist_we  = r_hist_we;
    assign io_bus.hist_wa  = r_hist_wa;
    assign io_bus.hist_wv  = r_hist_wv;
    assign io_bus.q_count  = w_count;
    assign io_bus.drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_branch_update_engine.sv
// Directed scoreboard bench for branch_update_engine: sweep, updates, forwarding, recovery, overflow.
module tb_branch_update_engine;
    import branch_update_engine_pkg::*;

    localparam int unsigned IN_WIDTH = 2;
    localparam int unsigned DEPTH    = 8;

    typedef struct packed {
        logic [IDX_W-1:0]   wa;
        logic [ENTRY_W-1:0] wv;
    } pht_wr_t;

    typedef struct packed {
        logic [IDX_W-1:0]  wa;
        logic [HIST_W-1:0] wv;
    } hist_wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_update_engine_if #(.IN_WIDTH(IN_WIDTH), .DEPTH(DEPTH)) bus ();

    branch_update_engine #(.IN_WIDTH(IN_WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .io_bus(bus)
    );

    pht_wr_t  pht_q[$];
    hist_wr_t hist_q[$];
    int       checks = 0;
    int       errors = 0;
    bit       sb_en = 1'b0;
    int       mcount;
    bit       mready;
    int       drops;
    int       n;
    int       pop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pht(input logic [IDX_W-1:0] wa, input logic [ENTRY_W-1:0] wv);
        pht_wr_t e;
        e.wa = wa;
        e.wv = wv;
        pht_q.push_back(e);
    endtask

    task automatic push_hist(input logic [IDX_W-1:0] wa, input logic [HIST_W-1:0] wv);
        hist_wr_t e;
        e.wa = wa;
        e.wv = wv;
        hist_q.push_back(e);
    endtask

    task automatic idle();
        bus.in_valid   = '0;
        bus.in_cond    = '0;
        bus.in_taken   = '0;
        bus.in_mispred = '0;
        bus.in_addr    = '0;
        bus.in_entry   = '0;
        bus.in_hist    = '0;
    endtask

    task automatic set_lane(input int l, input logic c, input logic t, input logic m,
                            input logic [ADDR_W-1:0] a, input logic [HIST_W-1:0] h,
                            input logic [ENTRY_W-1:0] e);
        bus.in_valid[l]   = 1'b1;
        bus.in_cond[l]    = c;
        bus.in_taken[l]   = t;
        bus.in_mispred[l] = m;
        bus.in_addr[l]    = a;
        bus.in_hist[l]    = h;
        bus.in_entry[l]   = e;
    endtask

    // Advance one clock and compare any table write against the head of its scoreboard queue.
    task automatic cycle();
        pht_wr_t  pe;
        hist_wr_t he;
        @(posedge clk);
        @(negedge clk);
        if (sb_en && bus.pht_we) begin
            if (pht_q.size() == 0) begin
                check("pht_unexpected_write", {60'd0, bus.pht_wa}, 64'hFFFF);
            end else begin
                pe = pht_q.pop_front();
                check("pht_wa", 64'(bus.pht_wa), 64'(pe.wa));
                check("pht_wv", 64'(bus.pht_wv), 64'(pe.wv));
            end
        end
        if (sb_en && bus.hist_we) begin
            if (hist_q.size() == 0) begin
                check("hist_unexpected_write", {60'd0, bus.hist_wa}, 64'hFFFF);
            end else begin
                he = hist_q.pop_front();
                check("hist_wa", 64'(bus.hist_wa), 64'(he.wa));
                check("hist_wv", 64'(bus.hist_wv), 64'(he.wv));
            end
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) cycle();
        check("rst_pht_we", 64'(bus.pht_we), 64'd0);
        check("rst_hist_we", 64'(bus.hist_we), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_q_count", 64'(bus.q_count), 64'd0);
        check("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);

        // Post-reset sweep
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cycle();
            check("sweep_we", {62'd0, bus.pht_we, bus.hist_we}, 64'd3);
            check("sweep_pht_wa", 64'(bus.pht_wa), 64'(k));
            check("sweep_pht_wv", 64'(bus.pht_wv), 64'hAAAA_AAAA);
            check("sweep_hist_wa", 64'(bus.hist_wa), 64'(k));
            check("sweep_hist_wv", 64'(bus.hist_wv), 64'd0);
            check("sweep_in_ready", 64'(bus.in_ready), 64'd0);
        end
        cycle();
        check("sweep_done_ready", 64'(bus.in_ready), 64'd1);
        check("sweep_done_we", 64'(bus.pht_we), 64'd0);
        sb_en = 1'b1;

        // Single taken update, ctr[3] 1 -> 2
        set_lane(0, 1'b1, 1'b1, 1'b0, 32'h14, 4'd3, 32'h1234_5678);
        push_pht(4'd5, 32'h1234_56B8);
        cycle();
        idle();
        check("single_latency_we", 64'(bus.pht_we), 64'd0);
        check("single_q_count", 64'(bus.q_count), 64'd1);
        cycle();
        check("single_we", 64'(bus.pht_we), 64'd1);
        cycle();

        // Saturation at both ends
        set_lane(0, 1'b1, 1'b1, 1'b0, 32'h14, 4'd3, 32'h0000_00C0);
        set_lane(1, 1'b1, 1'b0, 1'b0, 32'h20, 4'd0, 32'hFFFF_FFFC);
        push_pht(4'd5, 32'h0000_00C0);
        push_pht(4'd8, 32'hFFFF_FFFC);
        cycle();
        idle();
        cycle();
        check("sat_hi_we", 64'(bus.pht_we), 64'd1);
        cycle();
        check("sat_lo_we", 64'(bus.pht_we), 64'd1);
        cycle();

        // Non-conditional branch is not queued
        set_lane(0, 1'b0, 1'b1, 1'b0, 32'h14, 4'd3, 32'h0);
        cycle();
        idle();
        check("noncond_q_count", 64'(bus.q_count), 64'd0);
        cycle();
        check("noncond_we", 64'(bus.pht_we), 64'd0);
        cycle();

        // Forwarding between back-to-back same-index updates
        set_lane(0, 1'b1, 1'b1, 1'b0, 32'h14, 4'd3, 32'h0000_0040);
        set_lane(1, 1'b1, 1'b1, 1'b0, 32'h14, 4'd3, 32'h0000_0040);
        push_pht(4'd5, 32'h0000_0080);
        push_pht(4'd5, 32'h0000_00C0);
        cycle();
        idle();
        cycle();
        cycle();
        check("fwd_second_we", 64'(bus.pht_we), 64'd1);
        cycle();
        check("fwd_sb_drained", 64'(pht_q.size()), 64'd0);

        // History recovery: only the oldest mispredict restores history
        set_lane(0, 1'b1, 1'b1, 1'b1, 32'h30, 4'b1010, 32'h0);
        set_lane(1, 1'b1, 1'b0, 1'b1, 32'h34, 4'b0101, 32'hFFFF_FFFF);
        push_hist(4'd12, 4'b1011);
        push_pht(4'd12, 32'h0010_0000);
        push_pht(4'd13, 32'hFFFF_FBFF);
        cycle();
        idle();
        check("rec_we", 64'(bus.hist_we), 64'd1);
        cycle();
        check("rec_single", 64'(bus.hist_we), 64'd0);
        cycle();
        cycle();
        check("rec_pht_drained", 64'(pht_q.size()), 64'd0);
        check("rec_hist_drained", 64'(hist_q.size()), 64'd0);

        // Overflow: both lanes every cycle, occupancy tracked by a queue model
        mcount = 0;
        mready = 1'b1;
        drops  = 0;
        for (int c = 0; c < 10; c++) begin
            check("ovf_in_ready", 64'(bus.in_ready), 64'(mready));
            for (int l = 0; l < 2; l++) begin
                n = 2 * c + l;
                set_lane(l, 1'b1, 1'b1, 1'b0, 32'(n * 4), 4'(n % 16), 32'h0);
                if (mready) push_pht(4'(n % 16), 32'(1) << (2 * (n % 16)));
                else drops++;
            end
            pop    = (mcount > 0) ? 1 : 0;
            mcount = mcount + (mready ? 2 : 0) - pop;
            mready = (int'(DEPTH) - mcount >= 2);
            cycle();
            check("ovf_q_count", 64'(bus.q_count), 64'(mcount));
        end
        idle();
        check("ovf_drop_cnt", 64'(bus.drop_cnt), 64'(drops));
        repeat (10) cycle();
        check("ovf_sb_drained", 64'(pht_q.size()), 64'd0);
        check("ovf_q_empty", 64'(bus.q_count), 64'd0);

        // Reset in the middle of traffic
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < 2; l++) begin
                n = 2 * c + l;
                set_lane(l, 1'b1, 1'b1, 1'b0, 32'(n * 4), 4'(n % 16), 32'h0);
                push_pht(4'(n % 16), 32'(1) << (2 * (n % 16)));
            end
            cycle();
        end
        idle();
        rst_n = 1'b0;
        cycle();
        check("midrst_q_count", 64'(bus.q_count), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        check("midrst_pht_we", 64'(bus.pht_we), 64'd0);
        check("midrst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        cycle();
        pht_q.delete();
        sb_en = 1'b0;
        rst_n = 1'b1;
        cycle();
        check("resweep_first_we", 64'(bus.pht_we), 64'd1);
        check("resweep_first_wa", 64'(bus.pht_wa), 64'd0);
        repeat (15) cycle();
        check("resweep_last_wa", 64'(bus.pht_wa), 64'd15);
        cycle();
        check("resweep_ready", 64'(bus.in_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
